// File: rtl/i2c_master_reg_seq.sv
// i2c_master_reg_seq
//   Register-access sequencer in front of i2c_master_byte_ctrl. One request
//   handshake produces a complete register transaction: device address
//   (write), 1 or 2 register-address bytes, then either one data byte written
//   with stop, or a repeated start plus one byte read with stop.
//
// Build option:
//   I2C_SEQ_READ_EN - when defined, req_rnw_i is honoured and the read tail
//                     (repeated start + read) exists. When undefined every
//                     request is a write, bc_read_o/bc_ack_in_o/rsp_rdata_o
//                     are tied to zero.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_valid_i/ready_o request handshake (ready only while idle)
//   req_rnw_i           1 = read (read build only)
//   req_addr_i          register address, req_wdata_i write data
//   rsp_valid_o         one-cycle completion pulse
//   rsp_err_o           00 ok, 01 nack, 10 arbitration lost, 11 timeout
//   rsp_rdata_o         read data, valid with rsp_valid_o
//   bc_*_o              registered byte-controller command bits and byte
//   bc_cmd_ack_i        byte-controller command done pulse
//   bc_ack_out_i        slave ack bit of last write (1 = nack)
//   bc_dout_i           received byte, bc_al_i arbitration lost
module i2c_master_reg_seq #(
  parameter int unsigned ADDR_BYTES  = 2,
  parameter logic [6:0]  DEV_ADDR    = 7'h3C,
  parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rnw_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [1:0]  rsp_err_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        bc_start_o,
  output logic        bc_stop_o,
  output logic        bc_read_o,
  output logic        bc_write_o,
  output logic        bc_ack_in_o,
  output logic [7:0]  bc_din_o,
  input  logic        bc_cmd_ack_i,
  input  logic        bc_ack_out_i,
  input  logic [7:0]  bc_dout_i,
  input  logic        bc_al_i
);

  localparam logic [1:0] ERR_OK   = 2'b00;
  localparam logic [1:0] ERR_NACK = 2'b01;
  localparam logic [1:0] ERR_AL   = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV_W,
    S_ADDR_H,
    S_ADDR_L,
    S_DATA_W,
`ifdef I2C_SEQ_READ_EN
    S_DEV_R,
    S_DATA_R,
`endif
    S_NACK_STOP,
    S_DONE
  } state_e;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack_in;
    logic [7:0] din;
  } cmd_t;

  typedef struct packed {
`ifdef I2C_SEQ_READ_EN
    logic        rnw;
`endif
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  function automatic cmd_t mk_cmd(input logic st, input logic sp, input logic rd,
                                  input logic wr, input logic ai, input logic [7:0] d);
    cmd_t c;
    c.start  = st;
    c.stop   = sp;
    c.read   = rd;
    c.write  = wr;
    c.ack_in = ai;
    c.din    = d;
    return c;
  endfunction

  state_e      state_q, state_d;
  cmd_t        cmd_q, cmd_d;
  req_t        req_q, req_d;
  logic [19:0] cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
`ifdef I2C_SEQ_READ_EN
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
`endif

  // Completion request from inside the case; applied once at the end so
  // every exit path clears the command and pulses the response identically.
  logic        fin;
  logic [1:0]  fin_err;

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
`ifdef I2C_SEQ_READ_EN
    rsp_rdata_d = rsp_rdata_q;
`endif
    fin         = 1'b0;
    fin_err     = ERR_OK;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
`ifdef I2C_SEQ_READ_EN
          req_d.rnw = req_rnw_i;
`endif
          req_d.addr  = req_addr_i;
          req_d.wdata = req_wdata_i;
          state_d     = S_DEV_W;
          cmd_d       = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {DEV_ADDR, 1'b0});
          cnt_d       = '0;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: begin
        if (bc_al_i) begin
          // Bus is no longer ours: no stop, just abandon.
          fin     = 1'b1;
          fin_err = ERR_AL;
        end else if (bc_cmd_ack_i) begin
          cnt_d = '0;
          case (state_q)
            S_DEV_W, S_ADDR_H, S_ADDR_L
`ifdef I2C_SEQ_READ_EN
            , S_DEV_R
`endif
            : begin
              if (bc_ack_out_i) begin
                state_d = S_NACK_STOP;
                cmd_d   = mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
              end else if (state_q == S_DEV_W && ADDR_BYTES == 2) begin
                state_d = S_ADDR_H;
                cmd_d   = mk_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, req_q.addr[15:8]);
              end else if (state_q == S_DEV_W || state_q == S_ADDR_H) begin
                state_d = S_ADDR_L;
                cmd_d   = mk_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, req_q.addr[7:0]);
`ifdef I2C_SEQ_READ_EN
              end else if (state_q == S_ADDR_L && req_q.rnw) begin
                state_d = S_DEV_R;
                cmd_d   = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {DEV_ADDR, 1'b1});
              end else if (state_q == S_DEV_R) begin
                // Single-byte read: master nacks the byte, then stops.
                state_d = S_DATA_R;
                cmd_d   = mk_cmd(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
`endif
              end else begin
                state_d = S_DATA_W;
                cmd_d   = mk_cmd(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, req_q.wdata);
              end
            end
            // Stop already rides on this command, so a nack needs no extra stop.
            S_DATA_W: begin
              fin     = 1'b1;
              fin_err = bc_ack_out_i ? ERR_NACK : ERR_OK;
            end
`ifdef I2C_SEQ_READ_EN
            S_DATA_R: begin
              fin         = 1'b1;
              fin_err     = ERR_OK;
              rsp_rdata_d = bc_dout_i;
            end
`endif
            S_NACK_STOP: begin
              fin     = 1'b1;
              fin_err = ERR_NACK;
            end
            default: ;
          endcase
        end else if (cnt_q == TIMEOUT_CYC - 20'd1) begin
          fin     = 1'b1;
          fin_err = ERR_TO;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
    endcase

    if (fin) begin
      state_d     = S_DONE;
      cmd_d       = '0;
      cnt_d       = '0;
      rsp_valid_d = 1'b1;
      rsp_err_d   = fin_err;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      req_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= ERR_OK;
`ifdef I2C_SEQ_READ_EN
      rsp_rdata_q <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
`ifdef I2C_SEQ_READ_EN
      rsp_rdata_q <= rsp_rdata_d;
`endif
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign bc_start_o  = cmd_q.start;
  assign bc_stop_o   = cmd_q.stop;
  assign bc_write_o  = cmd_q.write;
  assign bc_din_o    = cmd_q.din;

`ifdef I2C_SEQ_READ_EN
  assign bc_read_o   = cmd_q.read;
  assign bc_ack_in_o = cmd_q.ack_in;
  assign rsp_rdata_o = rsp_rdata_q;
`else
  assign bc_read_o   = 1'b0;
  assign bc_ack_in_o = 1'b0;
  assign rsp_rdata_o = 8'h00;
  // Read-path inputs and command bits have no consumer in a write-only build.
  logic unused_rd;
  assign unused_rd = ^{req_rnw_i, bc_dout_i, cmd_q.read, cmd_q.ack_in};
`endif

endmodule

// File: tb/tb_i2c_master_reg_seq.sv
`timescale 1ns/1ps
module tb_i2c_master_reg_seq;
  localparam int          AB  = 2;
  localparam logic [6:0]  DEV = 7'h3C;
  localparam int          TO  = 16;
`ifdef I2C_SEQ_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_rnw = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid;
  logic [1:0]  rsp_err;
  logic [7:0]  rsp_rdata;
  logic        bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
  logic [7:0]  bc_din;
  logic        bc_cmd_ack = 1'b0, bc_ack_out = 1'b0, bc_al = 1'b0;
  logic [7:0]  bc_dout = '0;

  int total = 0;
  int bad   = 0;

  // Expected command list: {start,stop,read,write,ack_in,din}; din is only
  // meaningful for commands that write, so it is zeroed otherwise.
  logic [12:0] exp_q[$];
  logic [12:0] obs_q[$];
  logic [1:0]  exp_err;
  bit          exp_rd_ok;

  always #5 clk = ~clk;

  i2c_master_reg_seq #(.ADDR_BYTES(AB), .DEV_ADDR(DEV), .TIMEOUT_CYC(20'd16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rnw_i(req_rnw),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata),
    .bc_start_o(bc_start), .bc_stop_o(bc_stop), .bc_read_o(bc_read),
    .bc_write_o(bc_write), .bc_ack_in_o(bc_ack_in), .bc_din_o(bc_din),
    .bc_cmd_ack_i(bc_cmd_ack), .bc_ack_out_i(bc_ack_out), .bc_dout_i(bc_dout),
    .bc_al_i(bc_al)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [12:0] mk(input bit st, input bit sp, input bit rd,
                                     input bit wr, input bit ai, input logic [7:0] d);
    return {st, sp, rd, wr, ai, wr ? d : 8'h00};
  endfunction

  function automatic logic [12:0] cur_cmd();
    return {bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_write ? bc_din : 8'h00};
  endfunction

  // Reference: the full command list for a request, cut short by whichever
  // event (nack / arbitration loss / timeout) hits command index i.
  task automatic build_exp(input logic [15:0] a, input logic [7:0] wd, input bit rd_txn,
                           input int nk, input int al, input int to);
    logic [12:0] full[$];
    full = {};
    full.push_back(mk(1, 0, 0, 1, 0, {DEV, 1'b0}));
    if (AB == 2) full.push_back(mk(0, 0, 0, 1, 0, a[15:8]));
    full.push_back(mk(0, 0, 0, 1, 0, a[7:0]));
    if (rd_txn) begin
      full.push_back(mk(1, 0, 0, 1, 0, {DEV, 1'b1}));
      full.push_back(mk(0, 1, 1, 0, 1, 8'h00));
    end else begin
      full.push_back(mk(0, 1, 0, 1, 0, wd));
    end
    exp_q = {};
    exp_err = 2'b00;
    exp_rd_ok = rd_txn;
    for (int i = 0; i < full.size(); i++) begin
      exp_q.push_back(full[i]);
      if (i == al) begin exp_err = 2'b10; exp_rd_ok = 0; break; end
      if (i == to) begin exp_err = 2'b11; exp_rd_ok = 0; break; end
      if (i == nk && full[i][9]) begin
        exp_err = 2'b01; exp_rd_ok = 0;
        if (!full[i][11]) exp_q.push_back(mk(0, 1, 0, 0, 0, 8'h00));
        break;
      end
    end
  endtask

  // Drives one request and plays the byte controller. Event indices refer to
  // the n-th command issued; -1 means no such event.
  task automatic run_txn(input string nm, input logic [15:0] addr, input logic [7:0] wd,
                         input bit rnw, input int nk, input int al, input int to,
                         input logic [7:0] rd);
    int cyc, idx, wait_left, seen_cyc, rsp_cyc;
    bit waiting, acked_prev, done, gap_bad, stable_bad, busy_bad, first_bad, seq_bad;
    logic [12:0] rec, c, c_end;
    build_exp(addr, wd, rnw && RD_EN, nk, al, to);
    obs_q = {};
    idx = 0; waiting = 0; acked_prev = 0; done = 0; seen_cyc = 0; rsp_cyc = 0;
    gap_bad = 0; stable_bad = 0; busy_bad = 0; first_bad = 0; rec = '0; c_end = '0;
    wait_left = 0;

    @(negedge clk);
    req_valid = 1'b1; req_rnw = rnw; req_addr = addr; req_wdata = wd;
    total++;
    if (req_ready !== 1'b1)
      begin bad++; $display("FAIL %s ready_before: got %b want 1", nm, req_ready); end
    @(negedge clk);
    // Keep offering a different request while busy; it must be ignored.
    req_addr = ~addr; req_wdata = ~wd; req_rnw = ~rnw;
    cyc = 1;
    while (!done && cyc < 200) begin
      c = cur_cmd();
      if (acked_prev) begin
        bc_cmd_ack = 1'b0; bc_al = 1'b0; bc_ack_out = 1'b0; acked_prev = 0;
        if (c == 13'h0 && rsp_valid !== 1'b1) gap_bad = 1;
      end
      if (rsp_valid === 1'b1) begin
        done = 1; rsp_cyc = cyc; c_end = c;
        if (req_ready !== 1'b0) busy_bad = 1;
        req_valid = 1'b0;
      end else begin
        if (req_ready !== 1'b0) busy_bad = 1;
        if (!waiting && c != 13'h0) begin
          obs_q.push_back(c); rec = c; waiting = 1; seen_cyc = cyc;
          wait_left = $urandom_range(0, 3);
          if (idx == 0 && cyc != 1) first_bad = 1;
        end else if (waiting && c != rec) begin
          stable_bad = 1;
        end
        if (waiting && idx != to) begin
          if (wait_left == 0) begin
            if (idx == al) bc_al = 1'b1;
            else begin
              bc_cmd_ack = 1'b1; bc_ack_out = (idx == nk); bc_dout = rd;
            end
            acked_prev = 1; waiting = 0; idx++;
          end else wait_left--;
        end
        @(negedge clk);
        cyc++;
      end
    end

    total++;
    if (!done) begin
      bad++; $display("FAIL %s rsp_timeout: no rsp_valid within %0d cycles", nm, cyc);
      req_valid = 1'b0; bc_cmd_ack = 1'b0; bc_al = 1'b0;
      return;
    end
    seq_bad = (obs_q.size() != exp_q.size());
    for (int i = 0; i < obs_q.size() && !seq_bad; i++)
      if (obs_q[i] !== exp_q[i]) begin
        seq_bad = 1;
        $display("FAIL %s cmd[%0d]: got %h want %h", nm, i, obs_q[i], exp_q[i]);
      end
    total++;
    if (seq_bad) begin
      bad++; $display("FAIL %s cmd_seq: got %0d cmds want %0d", nm, obs_q.size(), exp_q.size());
    end
    total++;
    if (rsp_err !== exp_err)
      begin bad++; $display("FAIL %s rsp_err: got %b want %b", nm, rsp_err, exp_err); end
    total++;
    if (!RD_EN && rsp_rdata !== 8'h00)
      begin bad++; $display("FAIL %s rdata_tied: got %h want 00", nm, rsp_rdata); end
    else if (RD_EN && exp_rd_ok && rsp_rdata !== rd)
      begin bad++; $display("FAIL %s rdata: got %h want %h", nm, rsp_rdata, rd); end
    total++;
    if (c_end != 13'h0)
      begin bad++; $display("FAIL %s cmd_cleared: got %h want 0", nm, c_end); end
    total++;
    if (first_bad || gap_bad)
      begin bad++; $display("FAIL %s cmd_timing: first_late=%0d gap=%0d want 0 0", nm, first_bad, gap_bad); end
    total++;
    if (stable_bad || busy_bad)
      begin bad++; $display("FAIL %s stable_busy: unstable=%0d ready_busy=%0d want 0 0", nm, stable_bad, busy_bad); end
    if (to >= 0) begin
      total++;
      if (rsp_cyc - seen_cyc != TO)
        begin bad++; $display("FAIL %s timeout_cycles: got %0d want %0d", nm, rsp_cyc - seen_cyc, TO); end
    end
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
      begin bad++; $display("FAIL %s after_done: ready=%b valid=%b want 1 0", nm, req_ready, rsp_valid); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({req_ready, bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din,
         rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 5'b0, 8'h00, 1'b0, 2'b00, 8'h00})
      begin bad++; $display("FAIL reset_values: ready=%b cmd=%h din=%h v=%b err=%b rd=%h",
                            req_ready, cur_cmd(), bc_din, rsp_valid, rsp_err, rsp_rdata); end
    req_valid = 1'b1;
    @(negedge clk);
    total++;
    if (cur_cmd() != 13'h0 || req_ready !== 1'b1)
      begin bad++; $display("FAIL reset_holds: cmd=%h ready=%b want 0 1", cur_cmd(), req_ready); end
    req_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || cur_cmd() != 13'h0)
      begin bad++; $display("FAIL reset_release: ready=%b valid=%b cmd=%h", req_ready, rsp_valid, cur_cmd()); end
  endtask

  task automatic test_write_ack();
    run_txn("write_ack", 16'h3008, 8'h82, 1'b0, -1, -1, -1, 8'h00);
  endtask

  task automatic test_read_ack();
    run_txn("read_ack", 16'h300A, 8'h11, 1'b1, -1, -1, -1, 8'h56);
  endtask

  task automatic test_dev_nack();
    run_txn("dev_nack", 16'h1234, 8'h9A, 1'b0, 0, -1, -1, 8'h00);
    run_txn("data_nack", 16'h4321, 8'h5B, 1'b0, 3, -1, -1, 8'h00);
  endtask

  task automatic test_arb_lost();
    run_txn("arb_lost", 16'h300A, 8'h77, 1'b0, -1, 2, -1, 8'h00);
  endtask

  task automatic test_timeout();
    run_txn("timeout_dev", 16'h0102, 8'h03, 1'b0, -1, -1, 0, 8'h00);
    run_txn("timeout_data", 16'h0A0B, 8'h0C, 1'b0, -1, -1, 3, 8'h00);
  endtask

  task automatic test_reset_mid();
    bit hit;
    hit = 0;
    @(negedge clk);
    req_valid = 1'b1; req_rnw = 1'b0; req_addr = 16'hBEEF; req_wdata = 8'hA5;
    @(negedge clk);
    req_valid = 1'b0; bc_cmd_ack = 1'b1; bc_ack_out = 1'b0;
    // Acknowledging every cycle walks one command per cycle up to the data byte.
    for (int k = 0; k < 20 && !hit; k++) begin
      if (bc_stop === 1'b1 && bc_write === 1'b1) hit = 1;
      else @(negedge clk);
    end
    bc_cmd_ack = 1'b0;
    total++;
    if (!hit) begin bad++; $display("FAIL rst_mid_reach: data command never seen"); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({req_ready, bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din, rsp_valid, rsp_err}
        !== {1'b1, 5'b0, 8'h00, 1'b0, 2'b00})
      begin bad++; $display("FAIL rst_mid_values: ready=%b cmd=%h din=%h v=%b err=%b",
                            req_ready, cur_cmd(), bc_din, rsp_valid, rsp_err); end
    rst = 1'b0;
    hit = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) hit = 1;
    end
    total++;
    if (hit) begin bad++; $display("FAIL rst_mid_quiet: spurious response or not ready after reset"); end
    run_txn("rst_mid_next", 16'h3008, 8'h82, 1'b0, -1, -1, -1, 8'h00);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 25; n++) begin
      logic [15:0] a;
      logic [7:0]  w, r;
      bit          rnw;
      int          ev, ncmd, nk, al, to;
      a = 16'($urandom); w = 8'($urandom); r = 8'($urandom); rnw = 1'($urandom);
      ncmd = AB + 2 + ((rnw && RD_EN) ? 1 : 0);
      nk = -1; al = -1; to = -1;
      ev = $urandom_range(0, 4);
      case (ev)
        1: nk = $urandom_range(0, 3);
        2: al = $urandom_range(0, ncmd - 1);
        3: to = $urandom_range(0, ncmd - 1);
        default: ;
      endcase
      run_txn($sformatf("rand%0d", n), a, w, rnw, nk, al, to, r);
    end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read_ack();
    test_dev_nack();
    test_arb_lost();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
